avalon_st_framer: RTL

- Avalon-ST transmit-side framer: turns an unframed raw word stream plus a per-packet byte-length command into a framed Avalon-ST packet stream with data, empty, sop and eop.
- Sits upstream of the stream sampling/buffering stages.
- Drives their slave side with a single registered output stage.
- Honours downstream backpressure with zero data loss.

---
 rtl/avalon_st_framer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/avalon_st_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : avalon_st_framer                                             |
// | Description : Avalon-ST transmit framer. Takes a per-packet byte-length    |
// |               command and an unframed raw word stream, and produces a      |
// |               framed stream with sop/eop/empty through one registered     |
// |               output stage that honours downstream backpressure.          |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               cmd_vld/cmd_rdy/cmd_len   - packet length command (bytes)    |
// |               raw_vld/raw_rdy/raw_data  - raw words, byte 0 in MS byte     |
// |               out_vld/out_rdy/out_data/out_empty/out_sop/out_eop           |
// |                                         - framed Avalon-ST source          |
// |               busy    - packet in progress or output beat pending          |
// |               err_len - one-cycle pulse on a zero-length command           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module avalon_st_framer #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int LEN_WIDTH   = 16,
   localparam int SYMBOLS     = DATA_WIDTH / 8,
   localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_vld,
   output logic                   cmd_rdy,
   input  logic [LEN_WIDTH-1:0]   cmd_len,
   input  logic                   raw_vld,
   output logic                   raw_rdy,
   input  logic [DATA_WIDTH-1:0]  raw_data,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [EMPTY_WIDTH-1:0] out_empty,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic                   busy,
   output logic                   err_len
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   localparam logic [LEN_WIDTH-1:0] c_SYM_LEN = LEN_WIDTH'(SYMBOLS);
   localparam logic [LEN_WIDTH-1:0] c_ONE     = LEN_WIDTH'(1);

   generate
      if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH < 16)) begin : g_bad_width
         $fatal(1, "avalon_st_framer: DATA_WIDTH must be a multiple of 8 and >= 16");
      end
   endgenerate

   state_t                 state_q,      state_d;
   logic [LEN_WIDTH-1:0]   last_idx_q,   last_idx_d;
   logic [LEN_WIDTH-1:0]   beat_cnt_q,   beat_cnt_d;
   logic [EMPTY_WIDTH-1:0] last_empty_q, last_empty_d;
   logic                   out_vld_q,    out_vld_d;
   logic [DATA_WIDTH-1:0]  out_data_q,   out_data_d;
   logic [EMPTY_WIDTH-1:0] out_empty_q,  out_empty_d;
   logic                   out_sop_q,    out_sop_d;
   logic                   out_eop_q,    out_eop_d;
   logic                   err_len_q,    err_len_d;

   logic [LEN_WIDTH-1:0]   w_len_quot;
   logic [LEN_WIDTH-1:0]   w_len_rem;
   logic                   w_out_free;
   logic                   w_is_eop;
   logic [DATA_WIDTH-1:0]  w_raw_masked;

   // Index of the last beat is stored instead of the beat count so that a
   // maximum-length command never needs a wider-than-LEN_WIDTH counter.
   assign w_len_quot = cmd_len / c_SYM_LEN;
   assign w_len_rem  = cmd_len % c_SYM_LEN;
   assign w_out_free = ~out_vld_q | out_rdy;
   assign w_is_eop   = (beat_cnt_q == last_idx_q);

   // Zero the unused LS bytes of the final beat.
   always_comb begin : p_mask
      w_raw_masked = raw_data;
      for (int b = 0; b < SYMBOLS; b++) begin
         if (w_is_eop && (b < int'(last_empty_q))) begin
            w_raw_masked[8*b +: 8] = 8'h00;
         end
      end
   end

   always_comb begin : p_next
      state_d      = state_q;
      last_idx_d   = last_idx_q;
      beat_cnt_d   = beat_cnt_q;
      last_empty_d = last_empty_q;
      out_vld_d    = out_vld_q & ~out_rdy;
      out_data_d   = out_data_q;
      out_empty_d  = out_empty_q;
      out_sop_d    = out_sop_q;
      out_eop_d    = out_eop_q;
      err_len_d    = 1'b0;
      cmd_rdy      = 1'b0;
      raw_rdy      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_rdy = 1'b1;
            if (cmd_vld) begin
               if (cmd_len == '0) begin
                  err_len_d = 1'b1;
               end else begin
                  last_idx_d   = (w_len_rem != '0) ? w_len_quot : (w_len_quot - c_ONE);
                  last_empty_d = (w_len_rem == '0) ? '0
                                                   : EMPTY_WIDTH'(c_SYM_LEN - w_len_rem);
                  beat_cnt_d   = '0;
                  state_d      = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            // Pass-through refill: a new word may load on the same edge the
            // held beat is taken downstream.
            raw_rdy = w_out_free;
            if (raw_vld && w_out_free) begin
               out_vld_d   = 1'b1;
               out_data_d  = w_raw_masked;
               out_sop_d   = (beat_cnt_q == '0);
               out_eop_d   = w_is_eop;
               out_empty_d = w_is_eop ? last_empty_q : '0;
               beat_cnt_d  = beat_cnt_q + c_ONE;
               if (w_is_eop) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_idx_q   <= '0;
         beat_cnt_q   <= '0;
         last_empty_q <= '0;
         out_vld_q    <= 1'b0;
         out_data_q   <= '0;
         out_empty_q  <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         err_len_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_idx_q   <= last_idx_d;
         beat_cnt_q   <= beat_cnt_d;
         last_empty_q <= last_empty_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         out_empty_q  <= out_empty_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         err_len_q    <= err_len_d;
      end
   end

   assign out_vld   = out_vld_q;
   assign out_data  = out_data_q;
   assign out_empty = out_empty_q;
   assign out_sop   = out_sop_q;
   assign out_eop   = out_eop_q;
   assign err_len   = err_len_q;
   assign busy      = (state_q == ST_SEND) | out_vld_q;

endmodule
`default_nettype wire
